alu_sequencer: RTL and testbench

//  Multi-cycle arithmetic engine shared by the calculator controller during expression evaluation.

---
 rtl/alu_sequencer_pkg.sv | 24 ++
 rtl/alu_iter_step.sv | 34 +++
 rtl/alu_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: opcode and state
// encodings, the default datapath width and the iteration-step mode select.
package alu_sequencer_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_OUT  = 2'b10
  } state_e;

  // Step mode is the low opcode bit of the mul/div pair.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_iter_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// mul: acc = {partial_hi, multiplier_lo}; div: acc = {remainder, quotient}.
module alu_iter_step
  import alu_sequencer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           mode,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] top;
  logic [W:0] diff;

  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    top      = acc[2*W-1:W-1];
    diff     = top - {1'b0, operand};
    acc_next = '0;
    if (mode == MODE_MUL) begin
      // Carry-out of the partial sum shifts into the top of the accumulator.
      acc_next = {sum, acc[W-1:1]};
    end else if (diff[W]) begin
      acc_next = {top[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle unsigned add/sub/mul/div engine with valid/ready operation
// and result handshakes; mul and div retire one bit per clock.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [1:0]   opcode,
  input  logic [W-1:0] operand_a,
  input  logic [W-1:0] operand_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  state_e         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   operand_q;
  logic           mode;
  logic [CW-1:0]  cnt;
  logic [W:0]     add_res;
  logic [W:0]     sub_res;

  // Bit W is carry-out for add and borrow for sub.
  assign add_res = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_res = {1'b0, operand_a} - {1'b0, operand_b};

  alu_iter_step #(.W(W)) u_step (
    .acc      (acc),
    .operand  (operand_q),
    .mode     (mode),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      op_ready    <= 1'b1;
      res_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      acc         <= '0;
      operand_q   <= '0;
      mode        <= MODE_MUL;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            op_ready    <= 1'b0;
            case (opcode_e'(opcode))
              OP_ADD: begin
                result    <= add_res[W-1:0];
                overflow  <= add_res[W];
                res_valid <= 1'b1;
                state     <= S_OUT;
              end
              OP_SUB: begin
                result    <= sub_res[W-1:0];
                overflow  <= sub_res[W];
                res_valid <= 1'b1;
                state     <= S_OUT;
              end
              default: begin
                if (opcode[0] == MODE_DIV && operand_b == '0) begin
                  result      <= '1;
                  div_by_zero <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= S_OUT;
                end else begin
                  // mul walks the multiplier out of the low half; div walks
                  // the dividend out of the low half into the remainder.
                  acc       <= {{W{1'b0}}, (opcode[0] == MODE_MUL) ? operand_b : operand_a};
                  operand_q <= (opcode[0] == MODE_MUL) ? operand_a : operand_b;
                  mode      <= opcode[0];
                  cnt       <= CW'(W);
                  busy      <= 1'b1;
                  state     <= S_ITER;
                end
              end
            endcase
          end
        end
        S_ITER: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= acc_next[W-1:0];
            overflow  <= (mode == MODE_MUL) && (|acc_next[2*W-1:W]);
            busy      <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          op_ready  <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with hand-computed vectors.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [1:0]   opcode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one operation at a negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_valid  = 1'b1;
    opcode    = opc;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    op_valid  = 1'b0;
  endtask

  // Wait (bounded) for res_valid; reports latency and number of busy cycles.
  task automatic wait_result(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!res_valid && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_op_ready_after"}, op_ready, 1);
    check({tag, "_res_valid_after"}, res_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_dbz,
                        input logic exp_ov, input int exp_lat, input int exp_busy);
    int lat;
    int bc;
    start_op(opc, a, b);
    wait_result(lat, bc);
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_busy);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_div_by_zero"}, div_by_zero, exp_dbz);
    check({tag, "_overflow"}, overflow, exp_ov);
    check({tag, "_op_ready_out"}, op_ready, 0);
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    rst       = 1'b1;
    op_valid  = 1'b0;
    opcode    = OP_ADD;
    operand_a = '0;
    operand_b = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1, 1, 0);
    run_op("sub_50_70",   OP_SUB, 8'd50,  8'd70,  8'd236, 1'b0, 1'b1, 1, 0);
    run_op("sub_70_50",   OP_SUB, 8'd70,  8'd50,  8'd20,  1'b0, 1'b0, 1, 0);
    run_op("mul_7_9",     OP_MUL, 8'd7,   8'd9,   8'd63,  1'b0, 1'b0, 9, 8);
    run_op("mul_20_20",   OP_MUL, 8'd20,  8'd20,  8'd144, 1'b0, 1'b1, 9, 8);
    run_op("mul_255_255", OP_MUL, 8'd255, 8'd255, 8'd1,   1'b0, 1'b1, 9, 8);
    run_op("div_100_7",   OP_DIV, 8'd100, 8'd7,   8'd14,  1'b0, 1'b0, 9, 8);
    run_op("div_255_1",   OP_DIV, 8'd255, 8'd1,   8'd255, 1'b0, 1'b0, 9, 8);
    run_op("div_7_9",     OP_DIV, 8'd7,   8'd9,   8'd0,   1'b0, 1'b0, 9, 8);
    run_op("div_200_200", OP_DIV, 8'd200, 8'd200, 8'd1,   1'b0, 1'b0, 9, 8);
    run_op("div_5_0",     OP_DIV, 8'd5,   8'd0,   8'd255, 1'b1, 1'b0, 1, 0);

    // Backpressure: result held, op_valid ignored while in OUT.
    start_op(OP_SUB, 8'd70, 8'd50);
    wait_result(lat, bc);
    check("bp_res_valid", res_valid, 1);
    op_valid  = 1'b1;
    opcode    = OP_ADD;
    operand_a = 8'd1;
    operand_b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_res_valid", res_valid, 1);
      check("bp_hold_result", result, 20);
      check("bp_hold_overflow", overflow, 0);
      check("bp_hold_op_ready", op_ready, 0);
    end
    op_valid = 1'b0;
    consume("bp");

    // Reset during cycle 4 of 13*13 drops the operation.
    start_op(OP_MUL, 8'd13, 8'd13);
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_op_ready", op_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);

    // res_ready already high at accept: result still appears at cycle 1.
    res_ready = 1'b1;
    start_op(OP_ADD, 8'd3, 8'd4);
    wait_result(lat, bc);
    check("add_3_4_latency", lat, 1);
    check("add_3_4_res_valid", res_valid, 1);
    check("add_3_4_result", result, 7);
    check("add_3_4_overflow", overflow, 0);
    @(negedge clk);
    res_ready = 1'b0;
    check("add_3_4_op_ready_after", op_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
